// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB register path: FSM states, UART
// register map and default bus widths used by apb_initiator and its timer.
package uart_apb_pkg;

   localparam int unsigned APB_ADDR_W      = 8;
   localparam int unsigned APB_DATA_W      = 8;
   localparam int unsigned APB_TIMEOUT_CYC = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   // UART register slave address map
   localparam logic [7:0] UART_ADDR_BAUD    = 8'h00;
   localparam logic [7:0] UART_ADDR_TXDATA  = 8'h01;
   localparam logic [7:0] UART_ADDR_TXEN    = 8'h02;
   localparam logic [7:0] UART_ADDR_RXVALID = 8'h04;
   localparam logic [7:0] UART_ADDR_RXDATA  = 8'h05;

   // Width of a counter that must hold 0..n; never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state timer for the APB ACCESS phase. clear_i zeroes the count,
// enable_i advances it (saturating), expired_o flags the last permitted
// ACCESS cycle. TIMEOUT_CYC = 0 disables expiry entirely.
module apb_wait_timer
   import uart_apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CW   = cnt_width(TIMEOUT_CYC);
   localparam int unsigned LASTI = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam logic [CW-1:0] LAST = CW'(LASTI);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: clear has priority, increment saturates at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (TIMEOUT_CYC != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_initiator.sv
// APB3 initiator: converts a command/response handshake into one
// SETUP/ACCESS transfer at a time, with a bounded wait-state timeout.
// Optional macro APB_PSLVERR_EN adds the pslverr input and reports it
// through rsp_err; without it rsp_err signals only a timeout.
module apb_initiator
   import uart_apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = APB_ADDR_W,
   parameter int unsigned DATA_W      = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
`ifdef APB_PSLVERR_EN
   ,
   input  logic              pslverr
`endif
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              tmr_clear, tmr_enable, tmr_expired;

   apb_wait_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_wait_timer (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (tmr_clear),
      .enable_i (tmr_enable),
      .expired_o(tmr_expired)
   );

   // next-state and registered-output decode for the transfer FSM
   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      tmr_clear   = 1'b0;
      tmr_enable  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            tmr_clear = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // pready is checked before expiry so a late ready still succeeds
            if (pready) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_PSLVERR_EN
               rsp_err_d   = pslverr;
`else
               rsp_err_d   = 1'b0;
`endif
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (tmr_expired) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else begin
               tmr_enable = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Testbench for apb_initiator: directed transfers with a transaction-level
// model checked every cycle, plus literal latency/data expectations.
// Honours APB_PSLVERR_EN the same way as the design.
module tb_apb_initiator;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic [7:0] prdata = 8'h00;
   logic       pready = 1'b0;
   logic       pslverr = 1'b0;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   apb_initiator #(
      .ADDR_W(8),
      .DATA_W(8),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
`ifdef APB_PSLVERR_EN
      , .pslverr(pslverr)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: m_age counts edges since acceptance (0 = no bus
   // activity); edge m_age ends ACCESS cycle number m_age-1.
   int         m_age = 0;
   bit         m_rsp = 1'b0;
   logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'h00;
   logic       m_write = 1'b0, m_err = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_age <= 0; m_rsp <= 1'b0; m_addr <= 8'h00; m_wdata <= 8'h00;
         m_write <= 1'b0; m_rdata <= 8'h00; m_err <= 1'b0;
      end else if (m_rsp) begin
         if (rsp_ready) m_rsp <= 1'b0;
      end else if (m_age == 0) begin
         if (cmd_valid) begin
            m_age <= 1; m_addr <= cmd_addr; m_wdata <= cmd_wdata; m_write <= cmd_write;
         end
      end else if (m_age == 1) begin
         m_age <= 2;
      end else if (pready) begin
         m_age <= 0; m_rsp <= 1'b1;
         m_rdata <= m_write ? 8'h00 : prdata;
`ifdef APB_PSLVERR_EN
         m_err <= pslverr;
`else
         m_err <= 1'b0;
`endif
      end else if (TO != 0 && (m_age - 1) == TO) begin
         m_age <= 0; m_rsp <= 1'b1; m_rdata <= 8'h00; m_err <= 1'b1;
      end else begin
         m_age <= m_age + 1;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cmd_ready", cmd_ready, (m_age == 0) && !m_rsp);
         chk("psel", psel, m_age >= 1);
         chk("penable", penable, m_age >= 2);
         chk("rsp_valid", rsp_valid, m_rsp);
         chk("paddr", paddr, m_addr);
         chk("pwdata", pwdata, m_wdata);
         chk("pwrite", pwrite, m_write);
         if (m_rsp) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
         end
      end
   end

   // captures from the most recent transfer
   logic [1:0] s1, s2;
   logic [7:0] a2, d2;
   logic       w2;
   logic [7:0] cap_rdata;
   logic       cap_err;
   int         acc_n, lat_n;

   task automatic wait_accept();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         ok = cmd_ready;
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int waits, input logic [7:0] rd, input logic se,
                       input int hold);
      bit done;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      wait_accept();
      cmd_valid = 1'b0; cmd_addr = 8'hEE; cmd_wdata = 8'h11; cmd_write = ~w;
      lat_n = 1; acc_n = 0; done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         if (rsp_valid) begin
            done = 1'b1;
         end else begin
            if (lat_n == 1) s1 = {psel, penable};
            if (lat_n == 2) begin
               s2 = {psel, penable}; a2 = paddr; d2 = pwdata; w2 = pwrite;
            end
            if (psel && penable) begin
               acc_n++;
               pready = (acc_n == waits + 1);
               prdata = rd; pslverr = se;
            end else begin
               pready = 1'b0;
            end
            @(negedge clk);
            lat_n++;
         end
      end
      if (!done) chk("rsp_timeout", 0, 1);
      pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
      cap_rdata = rsp_rdata; cap_err = rsp_err;
      if (hold > 0) begin
         cmd_valid = 1'b1; cmd_addr = 8'h77; cmd_write = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, cap_rdata);
            chk("bp_cmd_ready", cmd_ready, 0);
         end
         cmd_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic exp_err;
      int   n;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_paddr", paddr, 8'h00);
      chk("rst_cmd_ready", cmd_ready, 1);
      rst = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);

      // zero-wait write
      xfer(1'b1, 8'h01, 8'hA5, 0, 8'h00, 1'b0, 0);
      chk("wr_setup", s1, 2'b10);
      chk("wr_access", s2, 2'b11);
      chk("wr_paddr", a2, 8'h01);
      chk("wr_pwdata", d2, 8'hA5);
      chk("wr_pwrite", w2, 1);
      chk("wr_latency", lat_n, 3);
      chk("wr_rdata", cap_rdata, 8'h00);
      chk("wr_err", cap_err, 0);

      // read with three wait states
      xfer(1'b0, 8'h05, 8'h00, 3, 8'h3C, 1'b0, 0);
      chk("rd3_access", acc_n, 4);
      chk("rd3_rdata", cap_rdata, 8'h3C);
      chk("rd3_err", cap_err, 0);

      // stuck slave times out
      xfer(1'b0, 8'h04, 8'h00, 1000, 8'hC3, 1'b0, 0);
      chk("to_access", acc_n, 16);
      chk("to_err", cap_err, 1);
      chk("to_rdata", cap_rdata, 8'h00);

      // ready on the final permitted cycle wins
      xfer(1'b0, 8'h05, 8'h00, 15, 8'h5A, 1'b0, 0);
      chk("late_access", acc_n, 16);
      chk("late_err", cap_err, 0);
      chk("late_rdata", cap_rdata, 8'h5A);

      // response backpressure, then back-to-back command
      xfer(1'b0, 8'h00, 8'h00, 0, 8'h96, 1'b0, 5);
      chk("bp_rdata_final", cap_rdata, 8'h96);
      xfer(1'b1, 8'h02, 8'h01, 0, 8'h00, 1'b0, 0);
      chk("b2b_latency", lat_n, 3);

      // reset during ACCESS wait states
      cmd_write = 1'b0; cmd_addr = 8'h03; cmd_valid = 1'b1;
      wait_accept();
      cmd_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         if (psel && penable) n++;
         pready = 1'b0;
         @(negedge clk);
      end
      chk("rst_mid_inaccess", {psel, penable}, 2'b11);
      rst = 1'b1;
      @(negedge clk);
      chk("rstm_psel", psel, 0);
      chk("rstm_penable", penable, 0);
      chk("rstm_rsp_valid", rsp_valid, 0);
      chk("rstm_paddr", paddr, 8'h00);
      chk("rstm_pwrite", pwrite, 0);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rstm_no_rsp", rsp_valid, 0);
      end
      xfer(1'b0, 8'h04, 8'h00, 1, 8'h99, 1'b0, 0);
      chk("post_rst_rdata", cap_rdata, 8'h99);
      chk("post_rst_access", acc_n, 2);

      // slave error on read of TXEN
      xfer(1'b0, 8'h02, 8'h00, 0, 8'h01, 1'b1, 0);
`ifdef APB_PSLVERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      chk("slverr_err", cap_err, exp_err);
      chk("slverr_rdata", cap_rdata, 8'h01);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=0 exp=1");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- APB3 requester (initiator) that turns a simple command/response handshake into APB SETUP/ACCESS transfers.
- Drives the same 8-bit APB peripheral bus as the UART controller's register slave.
- Used by the host-side sequencer or test harness to program and read the UART registers: baud, tx data, tx enable, rx status, rx data.
- One transfer in flight; bounded wait-state timeout so a hung slave cannot lock the bus.

Parameters:
- ADDR_W, 8, APB address width.
- DATA_W, 8, APB data width.
- TIMEOUT_CYC, 16, max ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  transfer failed (timeout, or pslverr if enabled).
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error; present only with APB_PSLVERR_EN.

Behaviour:
- Reset, synchronous on clk:
  - state=IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, timeout counter all 0.
- cmd_ready = (state==IDLE), combinational from state. No other output depends combinationally on inputs; all other outputs are registered.
- IDLE:
  - On cmd_valid&&cmd_ready: latch cmd_write/addr/wdata into pwrite/paddr/pwdata, set psel=1, go SETUP.
- SETUP (one cycle): psel=1, penable=0. Next state ACCESS with penable=1; counter cleared.
- ACCESS (psel=1, penable=1):
  - pready sampled each edge.
  - pready=1: psel=0, penable=0; rsp_rdata = pwrite ? 0 : prdata; rsp_err=0; rsp_valid=1; go RESP.
  - pready=0: counter+1.
  - If TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1 while pready=0: abort. psel=penable=0, rsp_err=1, rsp_rdata=0, rsp_valid=1, go RESP.
  - pready and timeout on the same edge: pready wins, no error.
- RESP:
  - rsp_valid/rdata/err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, go IDLE.
  - rsp_ready while not rsp_valid is ignored.
- paddr, pwdata, pwrite stay stable from SETUP through the final ACCESS cycle and hold their last values afterwards.
- Latency, zero-wait slave:
  - Accept at edge N; SETUP during N..N+1; ACCESS N+1..N+2; rsp_valid high after edge N+2.
  - With rsp_ready tied high, the next cmd is accepted 4 edges after the previous one.
- Wait states: each pready-low ACCESS cycle adds 1 cycle. Max ACCESS length is TIMEOUT_CYC cycles.
- Counter width is $clog2(TIMEOUT_CYC+1) and saturates, so there is no wrap.
- Reset mid-transfer: bus idles on the next edge (psel=penable=0), the transfer is dropped, and no response is issued.
- cmd_* changing while not accepted has no effect.

Optional Feature:
- APB_PSLVERR_EN defined:
  - pslverr port exists and is sampled with pready=1 in ACCESS.
  - rsp_err = pslverr; read data is still returned as prdata.
- Not defined:
  - No pslverr port; rsp_err is set only by timeout.

Decomposition:
- Shared package uart_apb_pkg:
  - State enum: IDLE, SETUP, ACCESS, RESP.
  - Address constants for UART registers: BAUD=0, TXDATA=1, TXEN=2, RXVALID=4, RXDATA=5.
  - Default widths.
- One sub-module, apb_wait_timer: clear/enable/expired counter parameterised by TIMEOUT_CYC.
- The FSM stays in apb_initiator.

Test Plan:
- Write, zero-wait: cmd write addr=0x01 wdata=0xA5, pready=1.
  - psel rises 1 edge after accept and penable 1 edge later; paddr=0x01, pwdata=0xA5, pwrite=1.
  - rsp_valid=1, rsp_err=0, rsp_rdata=0x00 after 3 edges.
- Read with 3 wait states: addr=0x05, pready low for 3 ACCESS cycles, then high with prdata=0x3C.
  - ACCESS lasts 4 cycles; rsp_rdata=0x3C, rsp_err=0.
- Timeout: TIMEOUT_CYC=16, pready stuck 0.
  - Exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_rdata=0.
  - pready asserted on cycle 16 gives rsp_err=0 instead.
- Response backpressure: rsp_ready low for 5 cycles.
  - rsp_valid/rdata held; cmd_ready=0 throughout; the next cmd is accepted only after the rsp handshake.
- Reset in ACCESS: assert rst during wait states.
  - Next edge all outputs 0, no rsp_valid; a following read of 0x04 completes normally.
- APB_PSLVERR_EN: pslverr=1 with pready on a read of 0x02 returning prdata=0x01.
  - rsp_err=1, rsp_rdata=0x01.
  - Without the macro, the same stimulus (minus pslverr) gives rsp_err=0.
